// File: rtl/cmd_frame_rx.sv
// cmd_frame_rx: receives HDR0 HDR1 CMDH CMDL frames and presents the 16-bit command.
// Define CMD_CHECKSUM_EN to add a trailing (CMDH+CMDL) mod 256 checksum byte.
module cmd_frame_rx #(
  parameter logic [7:0] HDR0 = 8'h55,
  parameter logic [7:0] HDR1 = 8'hAA,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        sys_clk,
  input  logic        clk_rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] recv_cmd,
  output logic        analysis_finish,
  output logic        frame_err,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYC);
`ifdef CMD_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR1, S_CMDH, S_CMDL, S_CSUM} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR1, S_CMDH, S_CMDL} state_t;
`endif
  state_t state, nxt;
  logic [7:0] cmd_hi;
  logic [15:0] new_cmd;
  logic [TW-1:0] tcnt;
  logic active, tout, done, bad;
`ifdef CMD_CHECKSUM_EN
  logic [7:0] cmd_lo;
  assign new_cmd = {cmd_hi, cmd_lo};
`else
  assign new_cmd = {cmd_hi, rx_data};
`endif
  // only the frame body is timed; header hunting may idle forever
  assign active = state != S_IDLE && state != S_HDR1;
  assign tout = active && !rx_valid && tcnt == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge sys_clk or negedge clk_rst_n)
    if (!clk_rst_n) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (rx_valid)
      case (state)
        S_IDLE:  nxt = rx_data == HDR0 ? S_HDR1 : S_IDLE;
        S_HDR1:  nxt = rx_data == HDR1 ? S_CMDH : rx_data == HDR0 ? S_HDR1 : S_IDLE;
        S_CMDH:  nxt = S_CMDL;
`ifdef CMD_CHECKSUM_EN
        S_CMDL:  nxt = S_CSUM;
`endif
        default: nxt = S_IDLE;
      endcase
    else if (tout)
      nxt = S_IDLE;
  end
  always_comb begin
    done = 1'b0;
    bad = tout;
`ifdef CMD_CHECKSUM_EN
    if (rx_valid && state == S_CSUM) begin
      done = rx_data == 8'(cmd_hi + cmd_lo);
      bad = !done;
    end
`else
    done = rx_valid && state == S_CMDL;
`endif
  end
  always_ff @(posedge sys_clk or negedge clk_rst_n)
    if (!clk_rst_n) begin
      recv_cmd <= '0;
      analysis_finish <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
      err_cnt <= '0;
      cmd_hi <= '0;
`ifdef CMD_CHECKSUM_EN
      cmd_lo <= '0;
`endif
      tcnt <= '0;
    end else begin
      analysis_finish <= done;
      frame_err <= bad;
      if (done) begin
        recv_cmd <= new_cmd;
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
      if (rx_valid && state == S_CMDH) cmd_hi <= rx_data;
`ifdef CMD_CHECKSUM_EN
      if (rx_valid && state == S_CMDL) cmd_lo <= rx_data;
`endif
      tcnt <= rx_valid || !active || tout ? '0 : tcnt + 1'b1;
    end
endmodule

// File: doc/cmd_frame_rx.md
CMD_FRAME_RX -- requirements
Module: cmd_frame_rx

Interface
REQ-001 SHALL have parameter HDR0, default 8'h55, first frame-header byte.
REQ-002 SHALL have parameter HDR1, default 8'hAA, second frame-header byte.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50000, maximum number of sys_clk cycles allowed between bytes inside a frame.
REQ-004 sys_clk  input  1  single clock; all logic on its rising edge.
REQ-005 clk_rst_n  input  1  asynchronous active-low reset.
REQ-006 rx_data  input  8  received byte from the FT232 byte path, already in the sys_clk domain.
REQ-007 rx_valid  input  1  one-cycle strobe; rx_data is valid when this is high.
REQ-008 recv_cmd  output  16  last accepted command, {cmd_hi, cmd_lo}.
REQ-009 analysis_finish  output  1  one-cycle pulse, new recv_cmd available.
REQ-010 frame_err  output  1  one-cycle pulse on a checksum failure or timeout.
REQ-011 frame_cnt  output  16  count of good frames; wraps from 16'hFFFF to 0.
REQ-012 err_cnt  output  8  count of errors; saturates at 8'hFF.

Function
REQ-013 The FSM SHALL use the states S_IDLE, S_HDR1, S_CMDH, S_CMDL and S_CSUM, and SHALL advance only on cycles where rx_valid=1.
REQ-014 S_IDLE: byte==HDR0 -> S_HDR1; any other byte is dropped silently.
REQ-015 S_HDR1: byte==HDR1 -> S_CMDH; byte==HDR0 stays in S_HDR1 to resync; any other byte -> S_IDLE; none of these raise frame_err.
REQ-016 S_CMDH: latch cmd_hi -> S_CMDL; S_CMDL: latch cmd_lo -> S_CSUM (CMD_CHECKSUM_EN defined) or complete the frame (not defined).
REQ-017 S_CSUM: if byte == (cmd_hi + cmd_lo) mod 256, complete the frame; otherwise error; both cases -> S_IDLE.
REQ-018 Completing a frame SHALL update recv_cmd and frame_cnt, and SHALL pulse analysis_finish for exactly one cycle, in the cycle after the final byte's rx_valid.
REQ-019 An error SHALL pulse frame_err for one cycle (same latency as REQ-018), increment err_cnt, and leave recv_cmd unchanged.
REQ-020 recv_cmd SHALL hold its value between frames; a partially received frame SHALL never alter recv_cmd.
REQ-021 The timeout counter SHALL clear on every rx_valid and increment each cycle while the FSM is not in S_IDLE or S_HDR1.
REQ-022 When the timeout counter reaches TIMEOUT_CYC-1, the block SHALL report an error and return to S_IDLE.
REQ-023 A byte arriving in the same cycle as a timeout SHALL win: it is processed and the timeout is ignored.
REQ-024 There is no backpressure: back-to-back rx_valid on every cycle SHALL be accepted, and a new frame's HDR0 may immediately follow the final byte.
REQ-025 The timeout counter SHALL be wide enough for TIMEOUT_CYC (clog2), and SHALL not wrap.

Reset
REQ-026 On clk_rst_n=0, asynchronously: FSM=S_IDLE, recv_cmd=16'h0000, analysis_finish=0, frame_err=0, frame_cnt=0, err_cnt=0, and the timeout counter and cmd latches are cleared.
REQ-027 A reset asserted mid-frame SHALL discard the partial frame; the first frame after release SHALL need a full header.

Configuration
REQ-028 Macro CMD_CHECKSUM_EN defined: frames are 5 bytes (HDR0, HDR1, CMDH, CMDL, CSUM) and checksum errors are reported.
REQ-029 CMD_CHECKSUM_EN undefined: frames are 4 bytes, S_CSUM and the checksum logic are absent, and frame_err is raised on timeout only.

Verification
REQ-030 The bench SHALL cover each scenario in REQ-031 to REQ-035; "with EN" means CMD_CHECKSUM_EN defined.
REQ-031 Good frame, with EN: 55 AA 12 34 46 -> recv_cmd=16'h1234, one-cycle analysis_finish, frame_cnt=1.
REQ-032 Bad checksum, with EN: 55 AA 12 34 47 -> frame_err pulse, err_cnt=1, recv_cmd unchanged, no analysis_finish.
REQ-033 Resync, with EN: 55 55 AA 00 01 01 -> recv_cmd=16'h0001 accepted; a stray byte 3C in S_IDLE -> no response.
REQ-034 Timeout, with TIMEOUT_CYC=16: 55 AA 12 then 16 idle cycles -> frame_err, FSM back to S_IDLE; the following 55 AA AB CD 78 is accepted.
REQ-035 Reset and saturation: reset asserted after 55 AA 12 -> no output, and a full frame after release is accepted; 256 bad frames -> err_cnt=8'hFF and held there.
